// File: rtl/hemaia_mem_pkg.sv
// Shared constants and types for the HeMAiA super-bank arbiter.
package hemaia_mem_pkg;

  localparam int unsigned BankStrbWidth = 8;
  localparam int unsigned StreakWidth   = 8;

  // Bank count of the standard 512-bit wide / 64-bit narrow super-bank.
  // Used to size the response owner record.
  localparam int unsigned SbNumBanks = 512 / 64;

  typedef struct packed {
    logic                  wide_rd;
    logic [SbNumBanks-1:0] nar_rd;
  } resp_owner_t;

endpackage

// File: rtl/hemaia_rsp_tracker.sv
// Delays the read-owner record by the SRAM latency so read data can be
// steered back to whichever requester issued the read.
module hemaia_rsp_tracker
  import hemaia_mem_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  resp_owner_t owner_i,
  output resp_owner_t owner_o
);

  resp_owner_t pipe_q [Depth];

  // Owner shift register; reset flushes in-flight responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= owner_i;
      for (int unsigned i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign owner_o = pipe_q[Depth-1];

endmodule

// File: rtl/hemaia_superbank_arbiter.sv
// Super-bank arbiter: wide TCDM path vs. per-bank narrow XDMA ports.
// Wide has priority; a saturating streak counter forces a narrow slot
// after MaxWideStreak consecutive wide grants with narrow pending.
module hemaia_superbank_arbiter
  import hemaia_mem_pkg::*;
#(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned WideDataWidth   = 512,
  parameter int unsigned MemAddrWidth    = 10,
  parameter int unsigned MaxWideStreak   = 8,
  parameter int unsigned MemLatency      = 1,
  localparam int unsigned NumBanks       = WideDataWidth / NarrowDataWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                wide_q_valid_i,
  output logic                                wide_q_ready_o,
  input  logic [MemAddrWidth-1:0]             wide_q_addr_i,
  input  logic                                wide_q_write_i,
  input  logic [WideDataWidth-1:0]            wide_q_data_i,
  input  logic [WideDataWidth/8-1:0]          wide_q_strb_i,
  output logic                                wide_p_valid_o,
  output logic [WideDataWidth-1:0]            wide_p_data_o,
  input  logic [NumBanks-1:0]                 nar_q_valid_i,
  output logic [NumBanks-1:0]                 nar_q_ready_o,
  input  logic [NumBanks*MemAddrWidth-1:0]    nar_q_addr_i,
  input  logic [NumBanks-1:0]                 nar_q_write_i,
  input  logic [NumBanks*NarrowDataWidth-1:0] nar_q_data_i,
  input  logic [NumBanks*8-1:0]               nar_q_strb_i,
  output logic [NumBanks-1:0]                 nar_p_valid_o,
  output logic [NumBanks*NarrowDataWidth-1:0] nar_p_data_o,
  output logic [NumBanks-1:0]                 mem_cs_o,
  output logic [NumBanks-1:0]                 mem_wen_o,
  output logic [NumBanks*MemAddrWidth-1:0]    mem_add_o,
  output logic [NumBanks*8-1:0]               mem_be_o,
  output logic [NumBanks*NarrowDataWidth-1:0] mem_wdata_o,
  input  logic [NumBanks*NarrowDataWidth-1:0] mem_rdata_i
);

  localparam logic [StreakWidth-1:0] StreakMax = StreakWidth'(MaxWideStreak);

  logic [StreakWidth-1:0] streak_q;
  logic                   any_nar;
  logic                   sel_narrow;
  logic                   wide_gnt;
  logic [NumBanks-1:0]    nar_gnt;
  resp_owner_t            owner_in;
  resp_owner_t            owner_tail;

  // Grant decision; gated by reset so no grant is visible while in reset.
  always_comb begin
    any_nar    = |nar_q_valid_i;
    sel_narrow = any_nar & (!wide_q_valid_i | (streak_q == StreakMax));
    wide_gnt   = wide_q_valid_i & !sel_narrow & !rst_i;
    nar_gnt    = (sel_narrow & !rst_i) ? nar_q_valid_i : '0;
  end

  // Count wide wins over a waiting narrow requester, saturating at the limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else if (!any_nar || sel_narrow) begin
      streak_q <= '0;
    end else if (wide_gnt && (streak_q != StreakMax)) begin
      streak_q <= streak_q + 1'b1;
    end
  end

  // Bank request mux; ungranted banks are driven fully to zero.
  always_comb begin
    mem_cs_o    = '0;
    mem_wen_o   = '0;
    mem_add_o   = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int unsigned j = 0; j < NumBanks; j++) begin
      if (wide_gnt) begin
        mem_cs_o[j]                                    = 1'b1;
        mem_wen_o[j]                                   = wide_q_write_i;
        mem_add_o[j*MemAddrWidth +: MemAddrWidth]      = wide_q_addr_i;
        mem_be_o[j*8 +: 8]                             = wide_q_strb_i[j*8 +: 8];
        mem_wdata_o[j*NarrowDataWidth +: NarrowDataWidth] =
          wide_q_data_i[j*NarrowDataWidth +: NarrowDataWidth];
      end else if (nar_gnt[j]) begin
        mem_cs_o[j]                                    = 1'b1;
        mem_wen_o[j]                                   = nar_q_write_i[j];
        mem_add_o[j*MemAddrWidth +: MemAddrWidth]      = nar_q_addr_i[j*MemAddrWidth +: MemAddrWidth];
        mem_be_o[j*8 +: 8]                             = nar_q_strb_i[j*8 +: 8];
        mem_wdata_o[j*NarrowDataWidth +: NarrowDataWidth] =
          nar_q_data_i[j*NarrowDataWidth +: NarrowDataWidth];
      end
    end
  end

  // Record which requester owns each granted read; writes never respond.
  always_comb begin
    owner_in         = '0;
    owner_in.wide_rd = wide_gnt & !wide_q_write_i;
    owner_in.nar_rd  = nar_gnt & ~nar_q_write_i;
  end

  hemaia_rsp_tracker #(
    .Depth (MemLatency)
  ) i_rsp_tracker (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .owner_i (owner_in),
    .owner_o (owner_tail)
  );

  assign wide_q_ready_o = wide_gnt;
  assign nar_q_ready_o  = nar_gnt;
  assign wide_p_valid_o = owner_tail.wide_rd;
  assign nar_p_valid_o  = owner_tail.nar_rd;
  assign wide_p_data_o  = mem_rdata_i;
  assign nar_p_data_o   = mem_rdata_i;

endmodule

// File: doc/hemaia_superbank_arbiter.md
Name: hemaia_superbank_arbiter

Overview:
- Per-super-bank arbiter between the wide (512-bit) TCDM path from the AXI-to-memory converter and the narrow (64-bit) XDMA TCDM ports.
- Drives the NumBanks 64-bit SRAM banks of one super-bank.
- Replaces static wide-priority selection: wide keeps priority, but a bounded starvation counter guarantees narrow forward progress.
- Tracks grant ownership across the memory latency and returns read data to the correct requester.

Parameters:
- NarrowDataWidth, 64, data width of one bank and one narrow port.
- WideDataWidth, 512, wide port data width; NumBanks = WideDataWidth/NarrowDataWidth (derived).
- MemAddrWidth, 10, bank word address width.
- MaxWideStreak, 8, max consecutive wide grants while any narrow request is pending; legal range 1..255.
- MemLatency, 1, SRAM read latency in cycles; legal range 1..4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- wide_q_valid_i  in  1  wide request valid
- wide_q_ready_o  out  1  wide request grant
- wide_q_addr_i  in  MemAddrWidth  bank word address (same for all banks)
- wide_q_write_i  in  1  1=write
- wide_q_data_i  in  WideDataWidth  write data; bank j takes bits [64j+63:64j]
- wide_q_strb_i  in  WideDataWidth/8  byte strobes
- wide_p_valid_o  out  1  wide read data valid
- wide_p_data_o  out  WideDataWidth  wide read data
- nar_q_valid_i  in  NumBanks  narrow request valid; port j targets bank j only
- nar_q_ready_o  out  NumBanks  narrow grants
- nar_q_addr_i  in  NumBanks*MemAddrWidth  narrow addresses
- nar_q_write_i  in  NumBanks  narrow write enables
- nar_q_data_i  in  NumBanks*NarrowDataWidth  narrow write data
- nar_q_strb_i  in  NumBanks*8  narrow strobes
- nar_p_valid_o  out  NumBanks  narrow read data valid
- nar_p_data_o  out  NumBanks*NarrowDataWidth  narrow read data
- mem_cs_o  out  NumBanks  bank chip select
- mem_wen_o  out  NumBanks  bank write enable
- mem_add_o  out  NumBanks*MemAddrWidth  bank address
- mem_be_o  out  NumBanks*8  bank byte enables
- mem_wdata_o  out  NumBanks*NarrowDataWidth  bank write data
- mem_rdata_i  in  NumBanks*NarrowDataWidth  bank read data, valid MemLatency cycles after cs

Behaviour:
- Ownership per cycle is all-wide or all-narrow; never mixed.
- Decision is combinational from the valids and the registered streak counter:
  - sel_narrow = |nar_q_valid_i & (!wide_q_valid_i | streak_q == MaxWideStreak).
  - Wide granted (wide_q_ready_o=1, all banks cs) iff wide_q_valid_i & !sel_narrow.
  - Narrow: every valid port granted in the same cycle (nar_q_ready_o = nar_q_valid_i); cs only on those banks.
- streak_q (8-bit counter):
  - Increment on a wide grant while any narrow is valid.
  - Clear on a narrow grant, or on any cycle with no narrow valid.
  - Saturates at MaxWideStreak.
- Ungranted bank: cs=0; addr/be/wdata/wen = 0.
- Read tracking: shift register MemLatency deep holding {wide_rd, nar_rd[NumBanks-1:0]}.
  - Bit set only for granted reads; writes produce no p_valid.
  - At the tail: wide_p_valid_o = wide_rd, nar_p_valid_o = nar_rd.
  - Data is routed from mem_rdata_i; *_p_data_o is don't-care when the corresponding valid is 0.
  - Back-to-back requests are accepted every cycle; there is no backpressure on responses.
- Simultaneous wide + narrow valid with streak_q < MaxWideStreak: wide wins and nar_q_ready_o = 0.
- Reset, while rst_i is high:
  - All *_ready_o, mem_cs_o, *_p_valid_o = 0; streak_q = 0; tracking pipe cleared.
  - Reset mid-operation drops in-flight responses; no p_valid emitted after reset release for requests granted before it.
- Handshake: requesters hold valid and payload until ready; the arbiter does not register requests.

Decomposition:
- Package hemaia_mem_pkg: bank strobe width constant (8), streak counter width, and a resp_owner_t packed struct {wide_rd, nar_rd[]}.
- One sub-module, hemaia_rsp_tracker: the MemLatency-deep owner shift register with async active-high reset.
- Arbitration and mux logic stay in the top module.

Test Plan:
- Wide-only read, addr=0x05, MemLatency=1 -> cs=all-ones and wen=0 at cycle t; wide_p_valid_o=1 at t+1 with mem_rdata concatenated; nar_p_valid_o=0.
- Narrow ports 0 and 3 write, addr 0x10/0x20, no wide -> both granted at t; mem_cs_o=0b1001; no p_valid at t+1.
- Wide valid continuously and narrow port 2 read pending, MaxWideStreak=8 -> 8 wide grants, then narrow port 2 granted on cycle 9 (wide_q_ready_o=0); streak resets, wide resumes on cycle 10.
- Wide read then narrow port 1 read on consecutive cycles, MemLatency=2 -> wide_p_valid at t+2, nar_p_valid_o[1] at t+3, no cross-routing.
- rst_i pulses 1 cycle after a wide read grant -> no wide_p_valid_o ever; all outputs 0 during reset; normal grant on the first cycle after release.
